rmii_rx_framer: RTL and testbench

//  RMII receive front-end, 100 Mbit/s mode. Assembles RXD dibits into bytes and strips preamble/SFD.

---
 rtl/rmii_rx_framer_pkg.sv | 28 ++
 rtl/eth_crc32_d8.sv | 20 ++
 rtl/rmii_rx_framer.sv | 169 ++++++++++++++++
 tb/tb_rmii_rx_framer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_rx_framer_pkg.sv
// Shared types and constants for the RMII receive framer: FSM states, SFD/CRC
// constants and error-bit positions.
package rmii_rx_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } state_t;

    localparam logic [1:0]  PRE_DIBIT   = 2'b01;
    localparam logic [1:0]  SFD_DIBIT   = 2'b11;
    localparam logic [1:0]  BAD_DIBIT   = 2'b10;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

    localparam int ERR_FCS   = 0;
    localparam int ERR_LEN   = 1;
    localparam int ERR_ALIGN = 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide reflected CRC-32 (poly 0x04C11DB7) next-state, purely combinational.
module eth_crc32_d8
    import rmii_rx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII 100M receive framer: dibit->byte assembly, preamble/SFD strip, FCS and
// length checks, byte stream out with sop/eop/error and saturating statistics.
module rmii_rx_framer
    import rmii_rx_framer_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int MIN_FRAME_BYTES = 64,
    parameter bit STRIP_FCS       = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  rmii_rxd,
    input  logic        rmii_crs_dv,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_error,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_errors
);

    // Holding the 4 FCS bytes back lets the eop ride on the last real data byte.
    localparam int DEPTH  = STRIP_FCS ? 5 : 1;
    localparam int HELD_W = $clog2(DEPTH + 1);
    localparam int CNT_W  = $clog2(MAX_FRAME_BYTES + 2);

    logic [1:0]              rxd_r;
    logic                    crs_r, crs_q;
    state_t                  state, state_nxt;
    logic [1:0]              phase;
    logic [5:0]              shreg;
    logic [31:0]             crc, crc_next;
    logic [CNT_W-1:0]        byte_cnt, cnt_inc;
    logic [HELD_W-1:0]       held;
    logic [DEPTH-1:0][7:0]   dline;
    logic                    sop_pend;
    logic                    start, take, byte_done, eof, eof_align;
    logic                    full, emit_data, emit_eop;
    logic [7:0]              new_byte;
    logic [2:0]              err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_r <= '0;
            crs_r <= 1'b0;
            crs_q <= 1'b0;
        end else begin
            rxd_r <= rmii_rxd;
            crs_r <= rmii_crs_dv;
            crs_q <= crs_r;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        eof       = 1'b0;
        eof_align = 1'b0;
        case (state)
            ST_IDLE: begin
                if (crs_r) begin
                    if (!enable)                 state_nxt = ST_DROP;
                    else if (rxd_r == PRE_DIBIT) state_nxt = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (!crs_r)                  state_nxt = ST_IDLE;
                else if (rxd_r == SFD_DIBIT) state_nxt = ST_DATA;
                else if (rxd_r == BAD_DIBIT) state_nxt = ST_DROP;
            end
            ST_DATA: begin
                // A lone low at phase 2 is the end-of-carrier toggle; the dibit is still good.
                if (crs_r)               take = 1'b1;
                else if (phase == 2'd0)  eof  = 1'b1;
                else if (!crs_q) begin
                    eof       = 1'b1;
                    eof_align = 1'b1;
                end
                else if (phase == 2'd2)  take = 1'b1;
                if (eof) state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                if (!crs_r && !crs_q) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign start     = (state == ST_PREAMBLE) && (state_nxt == ST_DATA);
    assign byte_done = take && (phase == 2'd3);
    assign new_byte  = {rxd_r, shreg};
    assign cnt_inc   = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;
    assign full      = (held == HELD_W'(DEPTH));
    assign emit_data = byte_done && full && (int'(cnt_inc) <= MAX_FRAME_BYTES);
    assign emit_eop  = eof && full;

    always_comb begin
        err            = '0;
        err[ERR_FCS]   = (crc != CRC_RESIDUE);
        err[ERR_LEN]   = (int'(byte_cnt) < MIN_FRAME_BYTES) || (int'(byte_cnt) > MAX_FRAME_BYTES);
        err[ERR_ALIGN] = eof_align;
    end

    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (new_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            shreg    <= '0;
            crc      <= CRC_INIT;
            byte_cnt <= '0;
            held     <= '0;
            dline    <= '0;
            sop_pend <= 1'b0;
        end else begin
            if (start) begin
                phase    <= '0;
                crc      <= CRC_INIT;
                byte_cnt <= '0;
                held     <= '0;
                sop_pend <= 1'b1;
            end else if (take) begin
                phase <= phase + 2'd1;
                shreg <= {rxd_r, shreg[5:2]};
                if (byte_done) begin
                    crc      <= crc_next;
                    byte_cnt <= cnt_inc;
                    if (!full) held <= held + 1'b1;
                    for (int i = DEPTH - 1; i > 0; i--) dline[i] <= dline[i-1];
                    dline[0] <= new_byte;
                end
            end
            if (emit_data || emit_eop) sop_pend <= 1'b0;
        end
    end

    // The eop beat can follow the last data beat directly when carrier drops at phase 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_error   <= '0;
            stat_frames <= '0;
            stat_errors <= '0;
        end else begin
            out_valid <= emit_data || emit_eop;
            out_data  <= (emit_data || emit_eop) ? dline[DEPTH-1] : '0;
            out_sop   <= (emit_data || emit_eop) && sop_pend;
            out_eop   <= emit_eop;
            out_error <= emit_eop ? err : '0;
            if (emit_eop && (err == '0)) stat_frames <= sat_inc16(stat_frames);
            else if (eof)                stat_errors <= sat_inc16(stat_errors);
        end
    end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: builds frames with a bench-side FCS, pushes
// the expected beat stream to a scoreboard and compares at the output.
module tb_rmii_rx_framer;

    localparam int MAXB = 1518;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  rxd = 2'b00;
    logic        crs = 1'b0;
    logic        out_valid, out_sop, out_eop;
    logic [7:0]  out_data;
    logic [2:0]  out_error;
    logic [15:0] stat_frames, stat_errors;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [2:0] err;
    } beat_t;

    beat_t sb[$];
    beat_t got, exp_b;
    int    n_assert = 0;
    int    n_fail   = 0;

    always #10 clk = ~clk;

    rmii_rx_framer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .rmii_rxd    (rxd),
        .rmii_crs_dv (crs),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_error   (out_error),
        .stat_frames (stat_frames),
        .stat_errors (stat_errors)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            got = {out_data, out_sop, out_eop, out_error};
            if (sb.size() == 0) begin
                n_assert++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_beat observed=%0h expected=none", got);
                end
            end else begin
                exp_b = sb.pop_front();
                check("beat{data,sop,eop,err}", {19'b0, got}, {19'b0, exp_b});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic make_frame(input int n, input int seed, output logic [7:0] q[$]);
        logic [31:0] c;
        logic [7:0]  b;
        q = {};
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n - 4; i++) begin
            b = 8'((i * 37 + seed) ^ (i >> 3));
            q.push_back(b);
            c = crc_byte(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
    endtask

    // Expected beats: byte i goes out when byte i+5 completes, unless the frame is
    // already past MAXB; the byte just ahead of the FCS carries eop.
    task automatic expect_frame(input logic [7:0] q[$], input logic [2:0] err);
        int n;
        bit first;
        n = q.size();
        first = 1'b1;
        if (n < 5) return;
        for (int i = 0; i + 5 < n; i++) begin
            if (i + 6 <= MAXB) begin
                sb.push_back({q[i], first, 1'b0, 3'b000});
                first = 1'b0;
            end
        end
        sb.push_back({q[n-5], first, 1'b1, err});
    endtask

    task automatic tick(input logic [1:0] d, input logic c);
        rxd = d;
        crs = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit tog);
        for (int p = 0; p < 4; p++) tick(b[2*p +: 2], !(tog && p == 2));
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] q[$], input int extra, input int tog_bytes);
        send_preamble();
        for (int i = 0; i < q.size(); i++) send_byte(q[i], i >= q.size() - tog_bytes);
        for (int e = 0; e < extra; e++) tick(2'b01, 1'b1);
        repeat (6) tick(2'b00, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    initial begin
        logic [7:0] q[$];

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_sop", 32'(out_sop), 0);
        check("rst_eop", 32'(out_eop), 0);
        check("rst_error", 32'(out_error), 0);
        check("rst_frames", 32'(stat_frames), 0);
        check("rst_errors", 32'(stat_errors), 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (3) tick(2'b00, 1'b0);

        // good 64-byte frame
        make_frame(64, 1, q);
        expect_frame(q, 3'b000);
        send_frame(q, 0, 0);
        drain("good64");
        check("good64_frames", 32'(stat_frames), 1);
        check("good64_errors", 32'(stat_errors), 0);

        // single payload bit flipped -> FCS bad
        make_frame(64, 2, q);
        q[20] = q[20] ^ 8'h01;
        expect_frame(q, 3'b001);
        send_frame(q, 0, 0);
        drain("fcsbad");
        check("fcsbad_errors", 32'(stat_errors), 1);

        // runt: 60 bytes with correct FCS
        make_frame(60, 3, q);
        expect_frame(q, 3'b010);
        send_frame(q, 0, 0);
        drain("runt");
        check("runt_errors", 32'(stat_errors), 2);

        // giant: 1519 bytes
        make_frame(1519, 4, q);
        expect_frame(q, 3'b010);
        send_frame(q, 0, 0);
        drain("giant");
        check("giant_errors", 32'(stat_errors), 3);

        // extra dibit after FCS -> alignment
        make_frame(64, 5, q);
        expect_frame(q, 3'b100);
        send_frame(q, 1, 0);
        drain("align");
        check("align_errors", 32'(stat_errors), 4);

        // end-of-carrier toggles at phase 2 over the last two bytes
        make_frame(64, 6, q);
        expect_frame(q, 3'b000);
        send_frame(q, 0, 2);
        drain("toggle");
        check("toggle_frames", 32'(stat_frames), 2);

        // reset mid-payload: 30 bytes in, 25 emitted, no eop
        make_frame(64, 7, q);
        for (int i = 0; i < 25; i++) sb.push_back({q[i], (i == 0), 1'b0, 3'b000});
        send_preamble();
        for (int i = 0; i < 30; i++) send_byte(q[i], 1'b0);
        repeat (3) tick(2'b01, 1'b1);
        reset_n = 1'b0;
        rxd = 2'b00;
        crs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_frames", 32'(stat_frames), 0);
        check("midrst_errors", 32'(stat_errors), 0);
        reset_n = 1'b1;
        repeat (3) tick(2'b00, 1'b0);
        drain("midrst");
        make_frame(64, 8, q);
        expect_frame(q, 3'b000);
        send_frame(q, 0, 0);
        drain("postrst");
        check("postrst_frames", 32'(stat_frames), 1);

        // enable low for a whole frame -> nothing, stats unchanged
        enable = 1'b0;
        make_frame(64, 9, q);
        send_frame(q, 0, 0);
        enable = 1'b1;
        drain("disabled");
        check("disabled_frames", 32'(stat_frames), 1);
        check("disabled_errors", 32'(stat_errors), 0);

        // 3-byte frame -> no output, counted as error
        q = {8'h11, 8'h22, 8'h33};
        send_frame(q, 0, 0);
        drain("short3");
        check("short3_errors", 32'(stat_errors), 1);
        check("short3_frames", 32'(stat_frames), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
